// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the multi-channel byte-serial memory arbiter.
package mem_arb_pkg;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } mem_arb_state_e;

    // Width codes 10 and 11 both mean a full word.
    function automatic logic [2:0] byte_count(input logic [1:0] width);
        case (width)
            W_BYTE:  byte_count = 3'd1;
            W_HALF:  byte_count = 3'd2;
            default: byte_count = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_nch_if.sv
// Requester-side and RAM-side signal bundle of the arbiter.
interface mem_arbiter_nch_if #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 32
);
    // A channel holds ch_req (with stable we/addr/wdata/width) until its one-cycle
    // ch_done pulse, and drops it during that pulse; ch_grant marks the serviced channel.
    logic [NUM_CH-1:0]        ch_req;
    logic [NUM_CH-1:0]        ch_we;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH*32-1:0]     ch_wdata;
    logic [NUM_CH*2-1:0]      ch_width;
    logic [NUM_CH-1:0]        ch_abort;
    logic [NUM_CH-1:0]        ch_grant;
    logic [NUM_CH-1:0]        ch_done;
    logic [31:0]              ch_rdata;
    logic [7:0]               mem_din;
    logic [7:0]               mem_dout;
    logic [ADDR_W-1:0]        mem_a;
    logic                     mem_wr;

    modport master (
        output ch_req, ch_we, ch_addr, ch_wdata, ch_width, ch_abort, mem_din,
        input  ch_grant, ch_done, ch_rdata, mem_dout, mem_a, mem_wr
    );

    modport slave (
        input  ch_req, ch_we, ch_addr, ch_wdata, ch_width, ch_abort, mem_din,
        output ch_grant, ch_done, ch_rdata, mem_dout, mem_a, mem_wr
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational channel selector: lowest index (mode 0) or first requester after ptr (mode 1).
module rr_arbiter #(
    parameter int  NUM_CH = 3,
    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    input  logic              mode,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  idx
);

    localparam logic [IDX_W:0]   NCH  = (IDX_W + 1)'(NUM_CH);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CH - 1);

    logic [IDX_W-1:0] start;
    logic [IDX_W:0]   cand;
    logic             found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        if (!mode || ptr == LAST) start = '0;
        else                      start = ptr + IDX_W'(1);
        // Scan circularly from start; the first requester seen wins.
        for (int i = 0; i < NUM_CH; i++) begin
            cand = {1'b0, start} + (IDX_W + 1)'(i);
            if (cand >= NCH) cand = cand - NCH;
            if (!found && req[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = cand[IDX_W-1:0];
            end
        end
        grant[idx] = found;
    end

endmodule

// File: rtl/mem_arbiter_nch.sv
// N-channel arbiter serialising 1/2/4-byte reads and writes onto a byte-wide RAM port.
module mem_arbiter_nch
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int ADDR_W   = 32,
    parameter int ARB_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    mem_arbiter_nch_if.slave bus,
    output mem_arb_state_e   state_dbg
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CH - 1);

    mem_arb_state_e    state_q, state_nxt;
    logic [IDX_W-1:0]  ptr_q, cidx_q, sel_idx;
    logic [NUM_CH-1:0] sel_grant;
    logic [ADDR_W-1:0] addr_q, sel_addr;
    logic [31:0]       wdata_q, sel_wdata, acc_q, acc_nxt;
    logic [1:0]        sel_width, cap_idx;
    logic [2:0]        n_q, step_q, e, cap_full;
    logic              sel_we, abort_c, accept, wr_last, rd_done, aborted;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req   (bus.ch_req),
        .ptr   (ptr_q),
        .mode  (ARB_MODE == ARB_RR),
        .grant (sel_grant),
        .idx   (sel_idx)
    );

    assign sel_addr  = bus.ch_addr[int'(sel_idx)*ADDR_W +: ADDR_W];
    assign sel_wdata = bus.ch_wdata[int'(sel_idx)*32 +: 32];
    assign sel_width = bus.ch_width[int'(sel_idx)*2 +: 2];
    assign sel_we    = bus.ch_we[sel_idx];
    assign abort_c   = bus.ch_abort[cidx_q];
    // e is the ordinal of the current edge counted from the acceptance edge.
    assign e         = step_q + 3'd1;
    assign cap_full  = e - 3'd2;
    assign cap_idx   = cap_full[1:0];
    assign state_dbg = state_q;

    always_comb begin
        acc_nxt = acc_q;
        acc_nxt[{cap_idx, 3'b000} +: 8] = bus.mem_din;
    end

    always_comb begin
        state_nxt = state_q;
        accept    = 1'b0;
        wr_last   = 1'b0;
        rd_done   = 1'b0;
        aborted   = 1'b0;
        case (state_q)
            ST_IDLE: if (|bus.ch_req) begin
                accept    = 1'b1;
                state_nxt = sel_we ? ST_WRITE : ST_READ;
            end
            ST_WRITE: if (step_q == n_q - 3'd1) begin
                wr_last   = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_READ, ST_DRAIN: begin
                // Abort beats a final capture landing on the same edge.
                if (abort_c) begin
                    aborted   = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (e == n_q + 3'd1) begin
                    rd_done   = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (e >= n_q - 3'd1) begin
                    state_nxt = ST_DRAIN;
                end else begin
                    state_nxt = ST_READ;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     state_q <= ST_IDLE;
        else if (rdy) state_q <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.mem_wr   <= 1'b0;
            bus.mem_a    <= '0;
            bus.mem_dout <= '0;
            bus.ch_grant <= '0;
            bus.ch_done  <= '0;
            bus.ch_rdata <= '0;
            ptr_q        <= LAST;
            cidx_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            acc_q        <= '0;
            n_q          <= 3'd1;
            step_q       <= '0;
        end else if (rdy) begin
            bus.ch_done <= '0;
            case (state_q)
                ST_IDLE: if (accept) begin
                    cidx_q       <= sel_idx;
                    addr_q       <= sel_addr;
                    wdata_q      <= sel_wdata;
                    n_q          <= byte_count(sel_width);
                    step_q       <= '0;
                    acc_q        <= '0;
                    bus.ch_grant <= sel_grant;
                    bus.mem_a    <= sel_addr;
                    bus.mem_wr   <= sel_we;
                    if (sel_we) bus.mem_dout <= sel_wdata[7:0];
                    if (ARB_MODE == ARB_RR) ptr_q <= sel_idx;
                end
                ST_WRITE: begin
                    if (wr_last) begin
                        bus.mem_wr          <= 1'b0;
                        bus.ch_grant        <= '0;
                        bus.ch_done[cidx_q] <= 1'b1;
                    end else begin
                        step_q       <= e;
                        bus.mem_a    <= addr_q + ADDR_W'(e);
                        bus.mem_dout <= wdata_q[{e[1:0], 3'b000} +: 8];
                    end
                end
                ST_READ, ST_DRAIN: begin
                    if (aborted) begin
                        bus.ch_grant <= '0;
                    end else begin
                        step_q <= e;
                        if (e <= n_q - 3'd1) bus.mem_a <= addr_q + ADDR_W'(e);
                        if (e >= 3'd2)       acc_q     <= acc_nxt;
                        if (rd_done) begin
                            bus.ch_rdata        <= acc_nxt;
                            bus.ch_grant        <= '0;
                            bus.ch_done[cidx_q] <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter_nch.sv
// Directed bench for mem_arbiter_nch: fixed-priority DUT plus a round-robin twin on the same requests.
module tb_mem_arbiter_nch;
    import mem_arb_pkg::*;

    localparam int NUM_CH = 3;
    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;
    mem_arb_state_e st_fix, st_rr;

    mem_arbiter_nch_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) bus ();
    mem_arbiter_nch_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) bus_rr ();

    int compared   = 0;
    int mismatched = 0;
    logic [39:0] exp_q[$];
    logic [7:0]  ram [logic [31:0]];
    logic [7:0]  ram_q = 8'h00;
    logic [NUM_CH-1:0] rr_exp [4] = '{3'b001, 3'b100, 3'b001, 3'b100};

    // clock / reset
    always #5 clk = ~clk;

    // Synchronous RAM model, stalled by rdy like the DUT.
    always @(posedge clk) begin
        if (rdy) begin
            ram_q <= ram.exists(bus.mem_a) ? ram[bus.mem_a] : 8'h00;
            if (bus.mem_wr) ram[bus.mem_a] = bus.mem_dout;
        end
    end
    assign bus.mem_din = ram_q;

    assign bus_rr.ch_req   = bus.ch_req;
    assign bus_rr.ch_we    = bus.ch_we;
    assign bus_rr.ch_addr  = bus.ch_addr;
    assign bus_rr.ch_wdata = bus.ch_wdata;
    assign bus_rr.ch_width = bus.ch_width;
    assign bus_rr.ch_abort = bus.ch_abort;
    assign bus_rr.mem_din  = 8'h00;

    mem_arbiter_nch #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .ARB_MODE(ARB_FIXED)) dut_fix (
        .clk(clk), .rst(rst), .rdy(rdy), .bus(bus), .state_dbg(st_fix)
    );

    mem_arbiter_nch #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .ARB_MODE(ARB_RR)) dut_rr (
        .clk(clk), .rst(rst), .rdy(rdy), .bus(bus_rr), .state_dbg(st_rr)
    );

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int c, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] width);
        bus.ch_we[c]              = we;
        bus.ch_addr[c*32 +: 32]   = addr;
        bus.ch_wdata[c*32 +: 32]  = wdata;
        bus.ch_width[c*2 +: 2]    = width;
    endtask

    // Steps through a queued write trace, one byte per cycle, then expects the done pulse.
    task automatic run_write_trace(input string tag, input logic [NUM_CH-1:0] g);
        logic [39:0] ex;
        while (exp_q.size() > 0) begin
            tick();
            ex = exp_q.pop_front();
            check({tag, "_a"}, bus.mem_a, ex[39:8]);
            check({tag, "_d"}, bus.mem_dout, ex[7:0]);
            check({tag, "_wr"}, bus.mem_wr, 1'b1);
            check({tag, "_gnt"}, bus.ch_grant, g);
            check({tag, "_nodone"}, bus.ch_done, 3'b000);
        end
        tick();
        check({tag, "_wr_off"}, bus.mem_wr, 1'b0);
        check({tag, "_done"}, bus.ch_done, g);
        check({tag, "_gnt_off"}, bus.ch_grant, 3'b000);
        bus.ch_req = '0;
        tick();
        check({tag, "_done_pulse"}, bus.ch_done, 3'b000);
    endtask

    initial begin
        bus.ch_req   = '0;
        bus.ch_we    = '0;
        bus.ch_addr  = '0;
        bus.ch_wdata = '0;
        bus.ch_width = '0;
        bus.ch_abort = '0;
        ram[32'h20] = 8'h80;
        ram[32'h21] = 8'h34;
        ram[32'h22] = 8'h12;
        ram[32'h60] = 8'h11;
        ram[32'h61] = 8'h22;
        ram[32'h62] = 8'h33;
        ram[32'h63] = 8'h44;

        // reset state
        tick();
        tick();
        check("rst_wr", bus.mem_wr, 1'b0);
        check("rst_a", bus.mem_a, 32'h0);
        check("rst_dout", bus.mem_dout, 8'h00);
        check("rst_gnt", bus.ch_grant, 3'b000);
        check("rst_done", bus.ch_done, 3'b000);
        check("rst_rdata", bus.ch_rdata, 32'h0);
        check("rst_state", st_fix, ST_IDLE);
        rst = 1'b1;
        tick();

        // ch1 word write 0xDEADBEEF @0x100
        set_ch(1, 1'b1, 32'h100, 32'hDEADBEEF, W_WORD);
        bus.ch_req = 3'b010;
        exp_q.push_back({32'h100, 8'hEF});
        exp_q.push_back({32'h101, 8'hBE});
        exp_q.push_back({32'h102, 8'hAD});
        exp_q.push_back({32'h103, 8'hDE});
        run_write_trace("wr_word", 3'b010);

        // ch0 byte read @0x20
        set_ch(0, 1'b0, 32'h20, 32'h0, W_BYTE);
        bus.ch_req = 3'b001;
        tick();
        check("rb_gnt", bus.ch_grant, 3'b001);
        check("rb_a", bus.mem_a, 32'h20);
        check("rb_wr", bus.mem_wr, 1'b0);
        tick();
        check("rb_nodone", bus.ch_done, 3'b000);
        tick();
        check("rb_done", bus.ch_done, 3'b001);
        check("rb_rdata", bus.ch_rdata, 32'h00000080);
        bus.ch_req = '0;
        tick();

        // ch0 half read @0x21
        set_ch(0, 1'b0, 32'h21, 32'h0, W_HALF);
        bus.ch_req = 3'b001;
        tick();
        check("rh_a0", bus.mem_a, 32'h21);
        tick();
        check("rh_a1", bus.mem_a, 32'h22);
        tick();
        check("rh_nodone", bus.ch_done, 3'b000);
        tick();
        check("rh_done", bus.ch_done, 3'b001);
        check("rh_rdata", bus.ch_rdata, 32'h00001234);
        bus.ch_req = '0;
        tick();

        // ch0 word read aborted in DRAIN while ch1 waits
        set_ch(0, 1'b0, 32'h40, 32'h0, W_WORD);
        set_ch(1, 1'b1, 32'h50, 32'hA5, W_BYTE);
        bus.ch_req = 3'b011;
        tick();
        check("ab_gnt0", bus.ch_grant, 3'b001);
        tick();
        tick();
        tick();
        check("ab_drain", st_fix, ST_DRAIN);
        bus.ch_abort = 3'b001;
        tick();
        check("ab_gnt_off", bus.ch_grant, 3'b000);
        check("ab_nodone", bus.ch_done, 3'b000);
        check("ab_idle", st_fix, ST_IDLE);
        check("ab_rdata_kept", bus.ch_rdata, 32'h00001234);
        bus.ch_abort = '0;
        bus.ch_req   = 3'b010;
        tick();
        check("ab_gnt1", bus.ch_grant, 3'b010);
        check("ab_a1", bus.mem_a, 32'h50);
        check("ab_d1", bus.mem_dout, 8'hA5);
        tick();
        check("ab_done1", bus.ch_done, 3'b010);
        bus.ch_req = '0;
        tick();

        // rdy low for 3 cycles in the middle of a word read
        set_ch(0, 1'b0, 32'h60, 32'h0, W_WORD);
        bus.ch_req = 3'b001;
        tick();
        check("rdy_a0", bus.mem_a, 32'h60);
        tick();
        tick();
        check("rdy_a2", bus.mem_a, 32'h62);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rdy_frz_a", bus.mem_a, 32'h62);
            check("rdy_frz_gnt", bus.ch_grant, 3'b001);
            check("rdy_frz_done", bus.ch_done, 3'b000);
            check("rdy_frz_st", st_fix, ST_READ);
        end
        rdy = 1'b1;
        tick();
        check("rdy_nodone6", bus.ch_done, 3'b000);
        tick();
        check("rdy_nodone7", bus.ch_done, 3'b000);
        tick();
        check("rdy_done", bus.ch_done, 3'b001);
        check("rdy_rdata", bus.ch_rdata, 32'h44332211);
        bus.ch_req = '0;
        tick();

        // ch0 and ch2 requesting continuously: fixed starves ch2, round-robin alternates
        rst = 1'b0;
        tick();
        rst = 1'b1;
        set_ch(0, 1'b1, 32'h200, 32'h11, W_BYTE);
        set_ch(2, 1'b1, 32'h300, 32'h33, W_BYTE);
        bus.ch_req = 3'b101;
        for (int t = 0; t < 4; t++) begin
            tick();
            check("arb_fix_gnt", bus.ch_grant, 3'b001);
            check("arb_rr_gnt", bus_rr.ch_grant, rr_exp[t]);
            tick();
            check("arb_fix_done", bus.ch_done, 3'b001);
            check("arb_rr_done", bus_rr.ch_done, rr_exp[t]);
            if (t == 3) bus.ch_req = '0;
        end
        tick();

        // async reset in the middle of a word write
        set_ch(2, 1'b1, 32'h80, 32'h01020304, W_WORD);
        bus.ch_req = 3'b100;
        tick();
        tick();
        tick();
        check("mr_a2", bus.mem_a, 32'h82);
        check("mr_wr_on", bus.mem_wr, 1'b1);
        #1;
        rst = 1'b0;
        #1;
        check("mr_wr_async", bus.mem_wr, 1'b0);
        check("mr_gnt_async", bus.ch_grant, 3'b000);
        check("mr_a_async", bus.mem_a, 32'h0);
        bus.ch_req = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("mr_idle", st_fix, ST_IDLE);
        check("mr_nodone", bus.ch_done, 3'b000);
        check("mr_wr_off", bus.mem_wr, 1'b0);

        // address wrap on a word write
        set_ch(1, 1'b1, 32'hFFFFFFFE, 32'h0A0B0C0D, W_WORD);
        bus.ch_req = 3'b010;
        exp_q.push_back({32'hFFFFFFFE, 8'h0D});
        exp_q.push_back({32'hFFFFFFFF, 8'h0C});
        exp_q.push_back({32'h00000000, 8'h0B});
        exp_q.push_back({32'h00000001, 8'h0A});
        run_write_trace("wrap", 3'b010);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_nch.md
Name: mem_arbiter_nch

Overview:
- Parametrised successor to the core memory controller and byte-serial accesser, merged into one block.
- Arbitrates NUM_CH requesters (I-fetch, load/store, future DMA/debug) onto the single byte-wide RAM port.
- Serialises 1/2/4-byte reads and writes, with fixed-priority or round-robin arbitration.
- Adds a per-channel abort for in-flight reads, e.g. I-fetch flush on branch.

Parameters:
- NUM_CH, 3: number of requesting channels; channel 0 has highest priority in fixed mode.
- ADDR_W, 32: address width; upper bits are passed to mem_a unchanged.
- ARB_MODE, 0: 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  in  1  system clock, rising edge only.
- rst  in  1  reset, asynchronous, active-low.
- rdy  in  1  global ready; low freezes every register.
- ch_req  in  NUM_CH  per-channel request, held high until that channel's done.
- ch_we  in  NUM_CH  1 = write, 0 = read.
- ch_addr  in  NUM_CH*ADDR_W  packed byte addresses.
- ch_wdata  in  NUM_CH*32  packed write data, little-endian.
- ch_width  in  NUM_CH*2  width code: 00 = byte, 01 = half, 10 and 11 = word.
- ch_abort  in  NUM_CH  cancel the granted channel's read.
- ch_grant  out  NUM_CH  one-hot; high while that channel is being serviced.
- ch_done  out  NUM_CH  one-cycle completion pulse.
- ch_rdata  out  32  read data, zero-extended; valid only while a done bit is high.
- mem_din  in  8  RAM read data.
- mem_dout  out  8  RAM write data.
- mem_a  out  ADDR_W  RAM address.
- mem_wr  out  1  RAM write strobe.

Behaviour:
- Reset (async, rst=0), effective immediately:
  - mem_wr=0, mem_a=0, mem_dout=0, ch_grant=0, ch_done=0, ch_rdata=0.
  - FSM goes to IDLE; round-robin pointer goes to NUM_CH-1.
  - A transfer in progress is dropped without done.
- rdy=0 freezes all state and outputs. RAM is stalled by the same rdy, so no byte is lost.
- All outputs are registered.
- Byte count n = 1, 2 or 4, taken from the width latched at grant.
- FSM states: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - At an edge with any ch_req high, select a channel c:
    - ARB_MODE 0: lowest index.
    - ARB_MODE 1: first requester after the pointer, circularly; the pointer is then set to c.
  - Latch addr, wdata, width and we of c; set ch_grant[c]; mem_a <= addr.
  - Write: mem_wr<=1, mem_dout<=byte0, go to WRITE.
  - Read: mem_wr<=0, go to READ.
- WRITE:
  - Edge k (k=1..n-1): mem_a<=addr+k, mem_dout<=byte k.
  - Edge n: mem_wr<=0, ch_grant<=0, ch_done[c]<=1, go to IDLE.
  - Done appears n cycles after acceptance.
  - Writes are not abortable; ch_abort is ignored in WRITE.
- READ:
  - Edges 1..n-1 issue addr+1..addr+n-1.
  - RAM data for the address presented after edge k is on mem_din before edge k+2.
  - Byte k is captured at edge k+2 into bits [8k+7:8k]; unused upper bytes read as 0.
  - State goes to DRAIN after the last address is issued.
- DRAIN: at edge n+1 the last byte is captured, ch_done[c]<=1, ch_grant<=0, go to IDLE. Read done appears n+1 cycles after acceptance.
- Abort: ch_abort[c] high at any READ/DRAIN edge returns the FSM to IDLE at that edge.
  - ch_grant clears and no done is issued; ch_rdata is unchanged.
  - Abort wins over a simultaneous final capture.
  - Abort on a non-granted channel is ignored.
- Done cycle: the FSM is in IDLE and re-arbitrates at the next edge.
  - The requester must drop ch_req during its done cycle, or it is accepted as a new request.
  - Back-to-back throughput is therefore one idle cycle per transfer.
- Address wrap: addr+k wraps modulo 2^ADDR_W.
- Request inputs that change while a channel is granted have no effect on the active transfer.

Decomposition:
- Package mem_arb_pkg holds:
  - width codes (W_BYTE, W_HALF, W_WORD);
  - the FSM state enum;
  - the width-to-byte-count function;
  - ARB_FIXED and ARB_RR constants.
- One sub-module, rr_arbiter (parameter NUM_CH):
  - inputs: request vector, pointer, mode;
  - outputs: one-hot grant and an encoded index;
  - purely combinational. The pointer register stays in the parent.

Test Plan:
- Ch1 word write 0xDEADBEEF @0x100 -> mem_a 0x100..0x103 with mem_dout EF,BE,AD,DE on 4 consecutive cycles, mem_wr high exactly 4 cycles, ch_done[1] 4 cycles after acceptance.
- Ch0 byte read @0x20, RAM byte 0x80 -> ch_rdata=0x00000080 with ch_done[0] 2 cycles after acceptance; half read of 0x1234 @0x21 -> 0x00001234 after 3 cycles.
- ARB_MODE 0, ch0 and ch2 requesting continuously -> ch0 served every transfer and ch2 starves. ARB_MODE 1, same stimulus -> grants alternate 0,2,0,2.
- Word read on ch0 with ch_abort[0] pulsed during DRAIN -> no ch_done, FSM back in IDLE, pending ch1 request granted next edge.
- rdy low for 3 cycles in the middle of a word read -> outputs frozen, correct 32-bit result, done delayed by exactly 3 cycles.
- rst low mid-write at byte 2 -> mem_wr=0 immediately with no clock edge; after release the FSM is idle and no done is issued. A word write @0xFFFFFFFE -> mem_a wraps 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
